// File: rtl/settings_hit_detector.sv
// Settings-menu cursor hit detector: accumulates per-frame overlaps between menu layers and the cursor layer.
// Optional macro SETTINGS_HIT_STICKY_EN adds hit_clr and makes hit_vec sticky across frames.
`ifndef PRIO_COUNT_SETTINGS
`define PRIO_COUNT_SETTINGS 4
`endif

module settings_hit_detector #(
  parameter int N_LAYERS     = `PRIO_COUNT_SETTINGS,
  parameter int CURSOR_LAYER = 0,
  parameter int IDX_W        = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                startOfFrame,
  input  logic                menu_active,
  input  logic [N_LAYERS-1:0] dr_prio_reg,
`ifdef SETTINGS_HIT_STICKY_EN
  input  logic                hit_clr,
`endif
  output logic [N_LAYERS-1:0] hit_vec,
  output logic                hit_any,
  output logic [IDX_W-1:0]    hit_idx,
  output logic                hit_new,
  output logic [N_LAYERS-1:0] new_vec
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state;
  logic [N_LAYERS-1:0] acc;
  logic [N_LAYERS-1:0] prev;
  logic [N_LAYERS-1:0] ov;
  logic [N_LAYERS-1:0] cursor_mask;

  assign cursor_mask = N_LAYERS'(1) << CURSOR_LAYER;
  assign ov = dr_prio_reg & {N_LAYERS{dr_prio_reg[CURSOR_LAYER]}} & ~cursor_mask;

  // The startOfFrame pixel always belongs to the frame it opens, so acc reloads with ov on every pulse.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state   <= IDLE;
      acc     <= '0;
      hit_vec <= '0;
      prev    <= '0;
      hit_new <= 1'b0;
    end else if (!menu_active) begin
      state   <= IDLE;
      acc     <= '0;
      hit_vec <= '0;
      prev    <= '0;
      hit_new <= 1'b0;
    end else begin
      hit_new <= 1'b0;
`ifdef SETTINGS_HIT_STICKY_EN
      if (hit_clr) begin
        hit_vec <= '0;
        prev    <= '0;
      end
`endif
      case (state)
        IDLE: begin
          if (startOfFrame) begin
            state <= RUN;
            acc   <= ov;
          end
        end
        RUN: begin
          if (startOfFrame) begin
            acc <= ov;
`ifdef SETTINGS_HIT_STICKY_EN
            // A simultaneous clear empties the history before this frame's hits are loaded.
            if (hit_clr) begin
              hit_vec <= acc;
              prev    <= '0;
              hit_new <= |acc;
            end else begin
              hit_vec <= hit_vec | acc;
              prev    <= hit_vec;
              hit_new <= |(acc & ~hit_vec);
            end
`else
            hit_vec <= acc;
            prev    <= hit_vec;
            hit_new <= |(acc & ~hit_vec);
`endif
          end else begin
            acc <= acc | ov;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign new_vec = hit_new ? (hit_vec & ~prev) : '0;
  assign hit_any = |hit_vec;

  // Descending scan so the lowest set index (highest priority) wins.
  always_comb begin
    hit_idx = '0;
    for (int i = N_LAYERS - 1; i >= 0; i--) begin
      if (hit_vec[i]) hit_idx = IDX_W'(i);
    end
  end

endmodule

// File: tb/tb_settings_hit_detector.sv
// Self-checking bench for settings_hit_detector: directed literal checks plus randomized frames against a frame-level model.
module tb_settings_hit_detector;

  localparam int NL = 4;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       startOfFrame = 1'b0;
  logic       menu_active = 1'b0;
  logic [3:0] dr_prio_reg = '0;
  logic [3:0] hit_vec;
  logic       hit_any;
  logic [1:0] hit_idx;
  logic       hit_new;
  logic [3:0] new_vec;
`ifdef SETTINGS_HIT_STICKY_EN
  logic       hit_clr = 1'b0;
`endif

  int assertCount = 0;
  int failCount = 0;
  bit checkEn = 1'b0;

  settings_hit_detector #(.N_LAYERS(NL), .CURSOR_LAYER(0)) dut (
    .clk(clk),
    .resetN(resetN),
    .startOfFrame(startOfFrame),
    .menu_active(menu_active),
    .dr_prio_reg(dr_prio_reg),
`ifdef SETTINGS_HIT_STICKY_EN
    .hit_clr(hit_clr),
`endif
    .hit_vec(hit_vec),
    .hit_any(hit_any),
    .hit_idx(hit_idx),
    .hit_new(hit_new),
    .new_vec(new_vec)
  );

  always #5 clk = ~clk;

  // Frame-level reference: which non-cursor layers shared a pixel with the cursor.
  function automatic int pixelHits(input int dr);
    if ((dr & 1) == 0) return 0;
    return dr & 'he;
  endfunction

  function automatic int lowestIdx(input int mask);
    for (int i = 0; i < NL; i++) if (((mask >> i) & 1) != 0) return i;
    return 0;
  endfunction

  bit modelInFrame;
  int frameHits, published, newHits;

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      modelInFrame <= 1'b0;
      frameHits    <= 0;
      published    <= 0;
      newHits      <= 0;
    end else if (!menu_active) begin
      modelInFrame <= 1'b0;
      frameHits    <= 0;
      published    <= 0;
      newHits      <= 0;
    end else if (startOfFrame) begin
      modelInFrame <= 1'b1;
      frameHits    <= pixelHits(int'(dr_prio_reg));
      if (modelInFrame) begin
        published <= frameHits;
        newHits   <= frameHits & ~published;
      end else begin
        newHits <= 0;
      end
    end else begin
      if (modelInFrame) frameHits <= frameHits | pixelHits(int'(dr_prio_reg));
      newHits <= 0;
    end
  end

  task automatic compareOne(input string name, input int act, input int exp);
    assertCount++;
    if (act != exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn && resetN) begin
      compareOne("model hit_vec", int'(hit_vec), published);
      compareOne("model hit_any", int'(hit_any), int'(published != 0));
      compareOne("model hit_idx", int'(hit_idx), lowestIdx(published));
      compareOne("model hit_new", int'(hit_new), int'(newHits != 0));
      compareOne("model new_vec", int'(new_vec), newHits);
    end
  end

  task automatic applyStimulus(input bit sof, input bit menu, input logic [3:0] dr);
    startOfFrame = sof;
    menu_active  = menu;
    dr_prio_reg  = dr;
    @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] expVec, input int expIdx,
                             input bit expNew, input logic [3:0] expNewVec);
    compareOne({name, " hit_vec"}, int'(hit_vec), int'(expVec));
    compareOne({name, " hit_any"}, int'(hit_any), int'(expVec != 0));
    compareOne({name, " hit_idx"}, int'(hit_idx), expIdx);
    compareOne({name, " hit_new"}, int'(hit_new), int'(expNew));
    compareOne({name, " new_vec"}, int'(new_vec), int'(expNewVec));
  endtask

  initial begin
    #12;
    checkOutput("reset", 4'b0000, 0, 1'b0, 4'b0000);
    resetN = 1'b1;
    #1;
    checkEn = 1'b1;
    @(posedge clk);
    #2;

    // Frame 1: one overlap with layer 2.
    applyStimulus(1'b1, 1'b1, 4'b0000);
    checkOutput("first sof", 4'b0000, 0, 1'b0, 4'b0000);
    applyStimulus(1'b0, 1'b1, 4'b0101);
    applyStimulus(1'b0, 1'b1, 4'b0000);
    applyStimulus(1'b1, 1'b1, 4'b0000);
    checkOutput("frame1", 4'b0100, 2, 1'b1, 4'b0100);
    applyStimulus(1'b0, 1'b1, 4'b0101);
    checkOutput("frame1 pulse end", 4'b0100, 2, 1'b0, 4'b0000);
    applyStimulus(1'b1, 1'b1, 4'b0000);
    checkOutput("frame2 repeat", 4'b0100, 2, 1'b0, 4'b0000);

    // Frame 3: two separate overlapping pixels.
    applyStimulus(1'b0, 1'b1, 4'b0011);
    applyStimulus(1'b0, 1'b1, 4'b1001);
    applyStimulus(1'b1, 1'b1, 4'b0000);
    checkOutput("frame3", 4'b1010, 1, 1'b1, 4'b1010);

    // Frame 4: cursor-only and non-cursor overlaps produce nothing.
    applyStimulus(1'b0, 1'b1, 4'b0001);
    applyStimulus(1'b0, 1'b1, 4'b0110);
    applyStimulus(1'b1, 1'b1, 4'b0000);
    checkOutput("frame4 none", 4'b0000, 0, 1'b0, 4'b0000);

    // All layers active sets every non-cursor bit.
    applyStimulus(1'b0, 1'b1, 4'b1111);
    applyStimulus(1'b1, 1'b1, 4'b0000);
    checkOutput("all layers", 4'b1110, 1, 1'b1, 4'b1110);

    // Menu drop mid-frame, two inactive frames, reactivation mid-frame.
    applyStimulus(1'b0, 1'b1, 4'b0101);
    applyStimulus(1'b0, 1'b0, 4'b0101);
    checkOutput("menu drop", 4'b0000, 0, 1'b0, 4'b0000);
    applyStimulus(1'b1, 1'b0, 4'b0011);
    applyStimulus(1'b0, 1'b0, 4'b0011);
    applyStimulus(1'b1, 1'b0, 4'b0011);
    applyStimulus(1'b0, 1'b1, 4'b0101);
    applyStimulus(1'b1, 1'b1, 4'b0000);
    checkOutput("reactivate sof", 4'b0000, 0, 1'b0, 4'b0000);
    applyStimulus(1'b0, 1'b1, 4'b1001);
    applyStimulus(1'b1, 1'b1, 4'b0000);
    checkOutput("reactivate frame", 4'b1000, 3, 1'b1, 4'b1000);

    // Asynchronous reset mid-frame with a pending accumulation.
    applyStimulus(1'b0, 1'b1, 4'b0111);
    resetN = 1'b0;
    #1;
    checkOutput("async reset", 4'b0000, 0, 1'b0, 4'b0000);
    resetN = 1'b1;
    applyStimulus(1'b1, 1'b1, 4'b0000);
    checkOutput("post reset sof", 4'b0000, 0, 1'b0, 4'b0000);
    applyStimulus(1'b0, 1'b1, 4'b0011);

    // Back-to-back startOfFrame pulses.
    applyStimulus(1'b1, 1'b1, 4'b0101);
    checkOutput("b2b first", 4'b0010, 1, 1'b1, 4'b0010);
    applyStimulus(1'b1, 1'b1, 4'b0000);
    checkOutput("b2b second", 4'b0100, 2, 1'b1, 4'b0100);

    // Randomized frames, checked every cycle by the compare process.
    for (int c = 0; c < 4000; c++) begin
      applyStimulus($urandom_range(0, 15) == 0, $urandom_range(0, 63) != 0,
                    4'($urandom_range(0, 15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/settings_hit_detector.md
Name: settings_hit_detector

Overview:
- Reads the settings-menu layer draw-request vector, the same bus that feeds the settings RGB priority mux, and detects which menu layers overlap the cursor layer on the same pixel.
- Accumulates overlaps over one video frame and publishes a registered per-frame hit vector, the highest-priority hit index and one-cycle "new hit" pulses at each startOfFrame.
- The settings FSM uses these outputs for item selection.
- Priority convention matches the mux: index 0 is the highest priority.

Parameters:
- N_LAYERS, default `PRIO_COUNT_SETTINGS: number of draw-request layers.
- CURSOR_LAYER, default 0: index of the cursor layer within dr_prio_reg; range 0..N_LAYERS-1.
- IDX_W, default $clog2(N_LAYERS) (minimum 1): width of hit_idx.

Ports:
- clk  in  1  pixel clock.
- resetN  in  1  reset, asynchronous, active-low.
- startOfFrame  in  1  one-cycle pulse at the first pixel of each frame.
- menu_active  in  1  high while the settings menu is displayed.
- dr_prio_reg  in  N_LAYERS  per-layer draw requests for the current pixel.
- hit_vec  out  N_LAYERS  layers that overlapped the cursor during the last complete frame.
- hit_any  out  1  OR of hit_vec.
- hit_idx  out  IDX_W  lowest set index of hit_vec; 0 when hit_vec==0.
- hit_new  out  1  one-cycle pulse when a frame publishes bits that were not set in the previous published hit_vec.
- new_vec  out  N_LAYERS  the newly set bits (hit_vec & ~prev hit_vec); valid only while hit_new=1, else 0.

Behaviour:
- Reset (async, resetN=0): acc, hit_vec, prev, new_vec = 0; hit_any = 0; hit_idx = 0; hit_new = 0; state = IDLE.
- Pixel overlap term: ov[i] = dr_prio_reg[i] & dr_prio_reg[CURSOR_LAYER] for i != CURSOR_LAYER; ov[CURSOR_LAYER] = 0.
- FSM has two states:
  - IDLE: entered on reset or whenever menu_active=0.
  - RUN: entered from IDLE on the first startOfFrame seen with menu_active=1.
  - Moving IDLE->RUN: that startOfFrame clears acc and loads acc=ov for the same cycle. Nothing is published because no complete frame exists yet.
- RUN, startOfFrame=0: acc <= acc | ov.
- RUN, startOfFrame=1, all registered and taking effect the next cycle:
  - hit_vec <= acc (excludes the current cycle's ov).
  - prev <= hit_vec.
  - new_vec <= acc & ~hit_vec.
  - hit_new <= |(acc & ~hit_vec).
  - acc <= ov (the startOfFrame pixel belongs to the new frame).
- hit_any and hit_idx are combinational from the registered hit_vec, so they change in the same cycle as hit_vec.
- hit_new is high for exactly one cycle. new_vec returns to 0 on the following cycle.
- Latency: from startOfFrame to updated hit_vec/hit_new is 1 clock.
- Going inactive: menu_active=0 in any cycle moves the FSM to IDLE and clears acc, hit_vec, prev and new_vec; hit_new=0. A partial frame is never published.
- Reactivating mid-frame: the FSM waits in IDLE for the next startOfFrame.
- Two consecutive frames with identical hits produce hit_new=0 for the second frame.
- A frame with no hits publishes hit_vec=0 and hit_new=0.
- Cursor-only pixels (no other layer active) produce no hit.
- All-layers-active pixel: every non-cursor bit is set.
- startOfFrame pulses in back-to-back cycles are legal. The second pulse publishes the single-pixel acc.

Optional Feature:
- Macro: SETTINGS_HIT_STICKY_EN.
- When defined:
  - Adds input port hit_clr (1 bit).
  - hit_vec becomes sticky: on publish, hit_vec <= hit_vec | acc. Bits stay set across frames until hit_clr=1.
  - hit_clr clears hit_vec and prev on the next clock.
  - If hit_clr and a publish occur in the same cycle, hit_clr wins first, then that frame's acc is loaded: hit_vec <= acc, prev <= 0, new_vec <= acc.
  - new_vec/hit_new are still computed against prev.
- When undefined: no hit_clr port; per-frame replace behaviour as above.

Test Plan:
- Reset, then N_LAYERS=4, CURSOR_LAYER=0, menu_active=1. Frame 1 contains one pixel with dr=4'b0101, then startOfFrame -> one cycle later hit_vec=4'b0100, hit_idx=2, hit_any=1, hit_new=1 for 1 cycle, new_vec=4'b0100.
- Frame 2 identical to frame 1 -> hit_vec=4'b0100, hit_new=0, new_vec=0.
- Frame 3 contains dr=4'b0011 and dr=4'b1001 on separate pixels -> hit_vec=4'b1010, hit_idx=1, hit_new=1, new_vec=4'b1010.
- Cursor-only pixels (dr=4'b0001) plus non-cursor overlap dr=4'b0110 in one frame -> hit_vec=0, hit_any=0, hit_idx=0, hit_new=0.
- menu_active dropped mid-frame after an overlap, raised again two frames later -> outputs 0 immediately on the next clock; the first startOfFrame after reactivation publishes nothing; the next startOfFrame publishes only the hits of the frame in between.
- resetN asserted mid-frame with acc=4'b0110 -> all outputs 0 asynchronously; the next startOfFrame publishes nothing.
- With SETTINGS_HIT_STICKY_EN: frame A hits 4'b0100, frame B hits 4'b0010 -> hit_vec=4'b0110. Then hit_clr pulse -> hit_vec=0.
